// File: rtl/wired_inst_buffer.sv
// Per-instruction circular instruction buffer between the icache response and decode.
// Compacts masked fetch slots in order, issues up to ISSUE_W per cycle, filters stale epochs.
module wired_inst_buffer #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 64,
  parameter int TID_W   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [TID_W-1:0]             flush_tid_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [TID_W-1:0]             in_tid_i,
  input  logic [FETCH_W-1:0]           in_mask_i,
  input  logic [FETCH_W*DATA_W-1:0]    in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [ISSUE_W-1:0]           out_mask_o,
  output logic [ISSUE_W*DATA_W-1:0]    out_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FETCH_CNT = CNT_W'(FETCH_W);
  localparam logic [CNT_W-1:0] ISSUE_CNT = CNT_W'(ISSUE_W);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TID_W-1:0]  cur_tid_q, cur_tid_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              in_ready_s;
  logic              push_fire_s;
  logic              tid_match_s;
  logic              write_en_s;
  logic [CNT_W-1:0]  push_n_s;
  logic [PTR_W-1:0]  slot_idx_s;
  logic              out_valid_s;
  logic              pop_fire_s;
  logic [CNT_W-1:0]  n_out_s;
  logic [CNT_W-1:0]  pop_n_s;

  // Offer side: oldest min(count, ISSUE_W) entries, contiguous from slot 0
  always_comb begin
    n_out_s     = (count_q < ISSUE_CNT) ? count_q : ISSUE_CNT;
    out_valid_s = (count_q != CNT_W'(0)) && !flush_i;
    out_mask_o  = {ISSUE_W{1'b0}};
    out_data_o  = {(ISSUE_W*DATA_W){1'b0}};
    for (int i = 0; i < ISSUE_W; i++) begin
      out_mask_o[i] = (CNT_W'(i) < n_out_s);
      out_data_o[i*DATA_W +: DATA_W] = mem_q[rd_ptr_q + PTR_W'(i)];
    end
    pop_fire_s = out_valid_s && out_ready_i;
    pop_n_s    = pop_fire_s ? n_out_s : CNT_W'(0);
  end

  // Input side: ready from registered count only; set mask bits packed in ascending slot order
  always_comb begin
    in_ready_s  = (DEPTH_CNT - count_q) >= FETCH_CNT;
    push_fire_s = in_valid_i && in_ready_s;
    tid_match_s = (in_tid_i == cur_tid_q);
    write_en_s  = push_fire_s && tid_match_s && !flush_i;
    push_n_s    = CNT_W'(0);
    slot_idx_s  = wr_ptr_q;
    mem_d       = mem_q;
    for (int i = 0; i < FETCH_W; i++) begin
      slot_idx_s = wr_ptr_q + PTR_W'(push_n_s);
      if (write_en_s && in_mask_i[i]) begin
        mem_d[slot_idx_s] = in_data_i[i*DATA_W +: DATA_W];
        push_n_s          = push_n_s + CNT_W'(1);
      end else begin
        push_n_s          = push_n_s;
      end
    end
  end

  // Pointer/count/epoch update; a redirect overrides any push or pop in the same cycle
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    cur_tid_d = cur_tid_q;
    drop_d    = 1'b0;
    if (flush_i) begin
      rd_ptr_d  = PTR_W'(0);
      wr_ptr_d  = PTR_W'(0);
      count_d   = CNT_W'(0);
      cur_tid_d = flush_tid_i;
      drop_d    = 1'b0;
    end else begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop_n_s);
      wr_ptr_d  = wr_ptr_q + PTR_W'(push_n_s);
      count_d   = count_q + push_n_s - pop_n_s;
      drop_d    = push_fire_s && !tid_match_s;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= PTR_W'(0);
      wr_ptr_q  <= PTR_W'(0);
      count_q   <= CNT_W'(0);
      cur_tid_q <= TID_W'(0);
      drop_q    <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      cur_tid_q <= cur_tid_d;
      drop_q    <= drop_d;
    end
  end

  // Payload storage, intentionally left unreset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_s;
  assign count_o     = count_q;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_wired_inst_buffer.sv
// Scoreboard bench for wired_inst_buffer (FETCH_W=2, ISSUE_W=2, DEPTH=8, DATA_W=32, TID_W=1).
module tb_wired_inst_buffer;

  localparam int FW = 2;
  localparam int IW = 2;
  localparam int DP = 8;
  localparam int DW = 32;
  localparam int TW = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i;
  logic [TW-1:0]   flush_tid_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [TW-1:0]   in_tid_i;
  logic [FW-1:0]   in_mask_i;
  logic [FW*DW-1:0] in_data_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [IW-1:0]   out_mask_o;
  logic [IW*DW-1:0] out_data_o;
  logic [3:0]      count_o;
  logic            drop_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  logic          model_tid;
  logic          exp_drop;

  always #5 clk = ~clk;

  wired_inst_buffer #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(DP), .DATA_W(DW), .TID_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_tid_i(flush_tid_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_tid_i(in_tid_i),
    .in_mask_i(in_mask_i), .in_data_i(in_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_mask_o(out_mask_o), .out_data_o(out_data_o),
    .count_o(count_o), .drop_o(drop_o)
  );

  task automatic idle_inputs();
    in_valid_i  = 1'b0;
    in_tid_i    = 1'b0;
    in_mask_i   = 2'b00;
    in_data_i   = 64'h0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    flush_tid_i = 1'b0;
  endtask

  // One clock of stimulus; the scoreboard pops and compares whatever the DUT offers.
  task automatic drive_cycle(input logic v, input logic tid, input logic [1:0] mask,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic ordy, input logic fl, input logic ftid);
    logic       exp_ready;
    logic       exp_valid;
    logic [1:0] exp_mask;
    int         n;
    in_valid_i  = v;
    in_tid_i    = tid;
    in_mask_i   = mask;
    in_data_i   = {d1, d0};
    out_ready_i = ordy;
    flush_i     = fl;
    flush_tid_i = ftid;
    @(negedge clk);
    exp_ready = (DP - exp_q.size()) >= FW;
    n         = (exp_q.size() < IW) ? exp_q.size() : IW;
    exp_valid = (exp_q.size() != 0) && !fl;
    exp_mask  = (n == 0) ? 2'b00 : ((n == 1) ? 2'b01 : 2'b11);
    checks++;
    if (in_ready_o !== exp_ready) begin
      errors++; $display("FAIL sb_in_ready: got %0b expected %0b", in_ready_o, exp_ready);
    end
    checks++;
    if (count_o !== 4'(exp_q.size())) begin
      errors++; $display("FAIL sb_count: got %0d expected %0d", count_o, exp_q.size());
    end
    checks++;
    if (drop_o !== exp_drop) begin
      errors++; $display("FAIL sb_drop: got %0b expected %0b", drop_o, exp_drop);
    end
    checks++;
    if (out_valid_o !== exp_valid) begin
      errors++; $display("FAIL sb_out_valid: got %0b expected %0b", out_valid_o, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (out_mask_o !== exp_mask) begin
        errors++; $display("FAIL sb_out_mask: got %b expected %b", out_mask_o, exp_mask);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (out_data_o[i*DW +: DW] !== exp_q[i]) begin
          errors++;
          $display("FAIL sb_data slot%0d: got %h expected %h", i, out_data_o[i*DW +: DW], exp_q[i]);
        end
      end
    end
    if (fl) begin
      exp_q.delete();
      model_tid = ftid;
      exp_drop  = 1'b0;
    end else begin
      if (exp_valid && ordy) begin
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
      end
      exp_drop = 1'b0;
      if (v && exp_ready) begin
        if (tid == model_tid) begin
          if (mask[0]) exp_q.push_back(d0);
          if (mask[1]) exp_q.push_back(d1);
        end else begin
          exp_drop = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      drive_cycle(1'b0, model_tid, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (exp_q.size() != 0 || count_o !== 4'd0) begin
      errors++; $display("FAIL drain: count %0d model %0d expected 0", count_o, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    model_tid = 1'b0;
    exp_drop  = 1'b0;
    #12;
    checks++;
    if (count_o !== 4'd0 || out_valid_o !== 1'b0 || out_mask_o !== 2'b00 ||
        in_ready_o !== 1'b1 || drop_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: count=%0d valid=%0b mask=%b ready=%0b drop=%0b expected 0/0/00/1/0",
               count_o, out_valid_o, out_mask_o, in_ready_o, drop_o);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 1'b0, 2'b11, 32'h1000_0001, 32'h1000_0002, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 2'b11, 32'h1000_0003, 32'h1000_0004, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 2'b01, 32'h1000_0005, 32'h1000_0006, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count_o !== 4'd5) begin
      errors++; $display("FAIL reset_prefill: count got %0d expected 5", count_o);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (count_o !== 4'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_midstream: count=%0d valid=%0b ready=%0b expected 0/0/1",
               count_o, out_valid_o, in_ready_o);
    end
    exp_q.delete();
    model_tid = 1'b0;
    exp_drop  = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 1'b0, 2'b11, 32'hAAAA_0000, 32'hBBBB_0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_data_o[31:0] !== 32'hAAAA_0000 || out_data_o[63:32] !== 32'hBBBB_0000) begin
      errors++; $display("FAIL reset_first_push: got %h expected bbbb0000aaaa0000", out_data_o);
    end
    drain();
  endtask

  task automatic test_compaction();
    drive_cycle(1'b1, model_tid, 2'b10, 32'h0000_00A0, 32'h0000_00B0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, model_tid, 2'b01, 32'h0000_00C0, 32'h0000_00D0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count_o !== 4'd2 || out_mask_o !== 2'b11 ||
        out_data_o[31:0] !== 32'h0000_00B0 || out_data_o[63:32] !== 32'h0000_00C0) begin
      errors++;
      $display("FAIL compaction: count=%0d mask=%b data=%h expected 2/11/000000c0000000b0",
               count_o, out_mask_o, out_data_o);
    end
    drain();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, model_tid, 2'b11, 32'h2000_0000 + 32'(2*k), 32'h2000_0001 + 32'(2*k),
                  1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (count_o !== 4'd8 || in_ready_o !== 1'b0) begin
      errors++; $display("FAIL full: count=%0d ready=%0b expected 8/0", count_o, in_ready_o);
    end
    drive_cycle(1'b1, model_tid, 2'b11, 32'h2EEE_0000, 32'h2EEE_0001, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count_o !== 4'd6 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL full_pop: count=%0d ready=%0b expected 6/1", count_o, in_ready_o);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int sent;
    logic       v;
    logic       ordy;
    logic [1:0] mask;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, model_tid, 2'b11, 32'h3000_0000 + 32'(2*k), 32'h3000_0001 + 32'(2*k),
                  1'b0, 1'b0, 1'b0);
    end
    drive_cycle(1'b1, model_tid, 2'b11, 32'h3000_0010, 32'h3000_0011, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count_o !== 4'd6) begin
      errors++; $display("FAIL push_pop_same_cycle: count got %0d expected 6", count_o);
    end
    drain();
    sent = 0;
    for (int k = 0; k < 2000 && sent < 64; k++) begin
      v    = 1'($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 1));
      mask = 2'($urandom_range(0, 3));
      if (v && ((DP - exp_q.size()) >= FW)) sent += $countones(mask);
      drive_cycle(v, model_tid, mask, $urandom, $urandom, ordy, 1'b0, 1'b0);
    end
    checks++;
    if (sent < 64) begin
      errors++; $display("FAIL stream_budget: sent %0d expected 64", sent);
    end
    drain();
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 1'b0, 2'b11, 32'h4000_0000, 32'h4000_0001, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 2'b11, 32'h4000_0002, 32'h4000_0003, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 2'b01, 32'h4000_0004, 32'h4000_0005, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 2'b11, 32'h4000_0006, 32'h4000_0007, 1'b1, 1'b1, 1'b1);
    checks++;
    if (count_o !== 4'd0 || drop_o !== 1'b0) begin
      errors++; $display("FAIL flush: count=%0d drop=%0b expected 0/0", count_o, drop_o);
    end
    drive_cycle(1'b1, 1'b0, 2'b11, 32'h4000_0008, 32'h4000_0009, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count_o !== 4'd0 || drop_o !== 1'b1) begin
      errors++; $display("FAIL stale_drop: count=%0d drop=%0b expected 0/1", count_o, drop_o);
    end
    drive_cycle(1'b1, 1'b1, 2'b11, 32'h4000_000A, 32'h4000_000B, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count_o !== 4'd2 || drop_o !== 1'b0) begin
      errors++; $display("FAIL new_epoch: count=%0d drop=%0b expected 2/0", count_o, drop_o);
    end
    drain();
  endtask

  task automatic test_single();
    drive_cycle(1'b1, model_tid, 2'b01, 32'h5000_0000, 32'h5000_0001, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid_o !== 1'b1 || out_mask_o !== 2'b01) begin
      errors++; $display("FAIL single_mask: valid=%0b mask=%b expected 1/01", out_valid_o, out_mask_o);
    end
    drive_cycle(1'b0, model_tid, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count_o !== 4'd0 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_pop: count=%0d valid=%0b expected 0/0", count_o, out_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_compaction();
    test_full();
    test_back_to_back();
    test_flush();
    test_single();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
